// File: rtl/buzzer_ctrl_pkg.sv
// Purpose : shared descriptor layout, FSM encoding and beep-sequencing helper for buzzer_ctrl.
// Latency : n/a (types, constants and one pure function).
// Backpressure: n/a.
package buzzer_ctrl_pkg;

    // Descriptor layout: {count[35:32], off_ticks[31:24], on_ticks[23:16], half_period[15:0]}
    localparam int DESC_W  = 36;
    localparam int HP_LSB  = 0;
    localparam int HP_W    = 16;
    localparam int ON_LSB  = 16;
    localparam int ON_W    = 8;
    localparam int OFF_LSB = 24;
    localparam int OFF_W   = 8;
    localparam int CNT_LSB = 32;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [OFF_W-1:0] off_ticks;
        logic [ON_W-1:0]  on_ticks;
        logic [HP_W-1:0]  half_period;
    } desc_t;

    // Where the sequencer lands when a new beep is due.
    typedef struct packed {
        state_e           state;
        logic [CNT_W-1:0] count;
        logic             done;
    } step_t;

    // Start the next beep with `count` beeps still outstanding. Zero-length
    // phases are skipped in the same cycle: a beep with on_ticks=0 is consumed
    // immediately, and if off_ticks is also 0 every remaining beep is empty,
    // so the pattern finishes at once.
    function automatic step_t beep_start(input logic [CNT_W-1:0] count,
                                         input logic [ON_W-1:0]  on_t,
                                         input logic [OFF_W-1:0] off_t);
        step_t s;
        s.state = ST_IDLE;
        s.count = '0;
        s.done  = 1'b1;
        if (count != '0) begin
            if (on_t != '0) begin
                s.state = ST_ON;
                s.count = count;
                s.done  = 1'b0;
            end else if (count != CNT_W'(1) && off_t != '0) begin
                s.state = ST_OFF;
                s.count = count - CNT_W'(1);
                s.done  = 1'b0;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/buzzer_ctrl_tone.sv
// Purpose : square-wave divider; output toggles every half_period cycles while enabled.
// Latency : first toggle half_period cycles after enable rises; output registered.
// Backpressure: none; en low clears counter and output to 0 on the next edge.
// Ports: clk, resetn (async active-low), en, half_period, tone (registered).
module buzzer_ctrl_tone
    import buzzer_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            tone
);

    logic [HP_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (!en || half_period == '0) begin
            // half_period=0 is a silent beep: hold low.
            div_cnt <= '0;
            tone    <= 1'b0;
        end else if (div_cnt == half_period - HP_W'(1)) begin
            div_cnt <= '0;
            tone    <= ~tone;
        end else begin
            div_cnt <= div_cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/buzzer_ctrl.sv
// Purpose : priority-arbitrated beep-pattern generator (count x {ON tone, OFF silence}).
// Latency : pattern starts the cycle after acceptance; done pulses the cycle IDLE is re-entered.
// Backpressure: req_ready only in IDLE, one-hot to the lowest valid index; non-preemptive.
// Ports: clk, resetn, req_valid/req_ready/req_desc per requester, abort,
//        buzzer (registered), busy, active_id, done, done_aborted.
module buzzer_ctrl
    import buzzer_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int CLKS_PER_TICK = 100000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc,
    input  logic                      abort,
    output logic                      buzzer,
    output logic                      busy,
    output logic [2:0]                active_id,
    output logic                      done,
    output logic                      done_aborted
);

    localparam int PRE_W = $clog2(CLKS_PER_TICK);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_dec;
    logic [HP_W-1:0]  hp_q;
    logic [ON_W-1:0]  on_q;
    logic [OFF_W-1:0] off_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       tick_q;
    logic [7:0]       phase_len;
    logic             phase_end;
    logic             timer_restart;
    logic             tone_en;
    logic             accept;
    logic             done_set, abort_set;
    logic             gnt_vld;
    logic [2:0]       gnt_idx;
    desc_t            gnt_desc;
    step_t            start_new, start_next;

    // Lowest asserted index wins; scanning downward leaves the lowest one last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end

    assign gnt_desc  = desc_t'(req_desc[gnt_idx*DESC_W +: DESC_W]);
    assign req_ready = (state_q == ST_IDLE && gnt_vld) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy      = (state_q != ST_IDLE);

    // Phase timer: prescaler counts clk cycles within a tick, tick_q counts ticks.
    assign phase_len = (state_q == ST_ON) ? on_q : off_q;
    assign phase_end = (state_q != ST_IDLE) &&
                       (pre_q == PRE_W'(CLKS_PER_TICK - 1)) &&
                       (tick_q == phase_len - 8'd1);

    assign cnt_dec    = cnt_q - CNT_W'(1);
    assign start_new  = beep_start(gnt_desc.count, gnt_desc.on_ticks, gnt_desc.off_ticks);
    assign start_next = beep_start(cnt_q, on_q, off_q);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        accept    = 1'b0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    accept    = 1'b1;
                    state_nxt = start_new.state;
                    cnt_nxt   = start_new.count;
                    done_set  = start_new.done;
                end
            end
            ST_ON: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    done_set  = 1'b1;
                    abort_set = 1'b1;
                end else if (phase_end) begin
                    cnt_nxt = cnt_dec;
                    if (cnt_dec == '0) begin
                        // Last beep: no trailing OFF phase.
                        state_nxt = ST_IDLE;
                        done_set  = 1'b1;
                    end else if (off_q != '0) begin
                        state_nxt = ST_OFF;
                    end else begin
                        state_nxt = ST_ON;
                    end
                end
            end
            ST_OFF: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    done_set  = 1'b1;
                    abort_set = 1'b1;
                end else if (phase_end) begin
                    state_nxt = start_next.state;
                    cnt_nxt   = start_next.count;
                    done_set  = start_next.done;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Any phase entry (including ON->ON back-to-back) restarts the timer.
    assign timer_restart = (state_nxt != state_q) || phase_end;

    // Tone is held in clear across each ON entry edge so every beep starts low.
    assign tone_en = (state_q == ST_ON) && (state_nxt == ST_ON) && !phase_end;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hp_q         <= '0;
            on_q         <= '0;
            off_q        <= '0;
            pre_q        <= '0;
            tick_q       <= '0;
            active_id    <= '0;
            done         <= 1'b0;
            done_aborted <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            done         <= done_set;
            done_aborted <= abort_set;
            if (accept) begin
                hp_q      <= gnt_desc.half_period;
                on_q      <= gnt_desc.on_ticks;
                off_q     <= gnt_desc.off_ticks;
                active_id <= gnt_idx;
            end
            if (timer_restart) begin
                pre_q  <= '0;
                tick_q <= '0;
            end else if (state_q != ST_IDLE) begin
                if (pre_q == PRE_W'(CLKS_PER_TICK - 1)) begin
                    pre_q  <= '0;
                    tick_q <= tick_q + 8'd1;
                end else begin
                    pre_q <= pre_q + PRE_W'(1);
                end
            end
        end
    end

    buzzer_ctrl_tone u_tone (
        .clk         (clk),
        .resetn      (resetn),
        .en          (tone_en),
        .half_period (hp_q),
        .tone        (buzzer)
    );

endmodule
